// File: rtl/dti_fifo_wr_arb_pkg.sv
// Shared types and parameter limits for the DTI FIFO write arbiter.
// Optional statistics are enabled by defining DTI_FIFO_WR_ARB_STAT_EN.
package dti_fifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned NumReqMin   = 2;
    localparam int unsigned NumReqMax   = 8;
    localparam int unsigned MaxBurstMin = 1;
    localparam int unsigned MaxBurstMax = 16;

    // Index width that stays at least one bit wide.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dti_rr_arbiter.sv
// Combinational round-robin picker: searches req starting one past rr_ptr, wrapping at NUM_REQ.
module dti_rr_arbiter
    import dti_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = idx_width(NUM_REQ),
    localparam int unsigned CandW  = IdxW + 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    rr_ptr,
    output logic [IdxW-1:0]    winner,
    output logic               valid
);

    logic [CandW-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        winner = rr_ptr;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            // rr_ptr + k is below 2*NUM_REQ, so one conditional subtract is the modulo.
            cand = {1'b0, rr_ptr} + CandW'(k);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!valid && req[cand[IdxW-1:0]]) begin
                valid  = 1'b1;
                winner = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/dti_fifo_wr_arb.sv
// Round-robin burst arbiter feeding the write side of an async FIFO.
// Define DTI_FIFO_WR_ARB_STAT_EN to add the err_sticky / err_cnt write-error statistics.
module dti_fifo_wr_arb
    import dti_fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 21,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IdxW      = idx_width(NUM_REQ),
    localparam int unsigned CntW      = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_req,
    output logic [DATA_WIDTH-1:0]         fifo_wr_din,
    input  logic                          fifo_wr_full,
    input  logic                          fifo_wr_prog_full,
    input  logic                          fifo_wr_error,
    output logic [IdxW-1:0]               grant_id,
    output logic                          busy
`ifdef DTI_FIFO_WR_ARB_STAT_EN
    ,
    output logic                          err_sticky,
    output logic [15:0]                   err_cnt
`endif
);

    if (NUM_REQ < NumReqMin || NUM_REQ > NumReqMax) begin : gen_bad_num_req
        $error("dti_fifo_wr_arb: NUM_REQ out of range");
    end
    if (MAX_BURST < MaxBurstMin || MAX_BURST > MaxBurstMax) begin : gen_bad_max_burst
        $error("dti_fifo_wr_arb: MAX_BURST out of range");
    end

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] gid_q, gid_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] arb_winner;
    logic            arb_valid;
    logic            accept;

    dti_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (rr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid && !fifo_wr_prog_full) begin
                    state_d = GRANT;
                    gid_d   = arb_winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // prog_full never preempts a running burst; only full stalls it.
                req_ready[gid_q] = !fifo_wr_full;
                accept           = req_valid[gid_q] && !fifo_wr_full;
                if (accept) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (req_last[gid_q] || cnt_d == CntW'(MAX_BURST)) begin
                        state_d = IDLE;
                        rr_d    = gid_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset_n) begin
            req_ready = '0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gid_q   <= '0;
            rr_q    <= IdxW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_wr_req = accept;
    assign fifo_wr_din = req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id    = gid_q;
    assign busy        = (state_q == GRANT) && reset_n;

`ifdef DTI_FIFO_WR_ARB_STAT_EN
    logic        err_sticky_q, err_sticky_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (fifo_wr_error) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
`else
    logic unused_fifo_wr_error;
    assign unused_fifo_wr_error = fifo_wr_error;
`endif

endmodule

// File: tb/tb_dti_fifo_wr_arb.sv
// Directed, table-driven bench for dti_fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=21, MAX_BURST=4).
module tb_dti_fifo_wr_arb;

    localparam int unsigned NReq = 4;
    localparam int unsigned DW   = 21;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic       pfull;
        logic       err;
        logic [3:0] exp_ready;
        logic       exp_wr;
        logic [1:0] exp_gid;
        logic       exp_busy;
    } vec_t;

    logic               clk;
    logic               reset_n;
    logic [NReq-1:0]    req_valid;
    logic [NReq*DW-1:0] req_data;
    logic [NReq-1:0]    req_last;
    logic [NReq-1:0]    req_ready;
    logic               fifo_wr_req;
    logic [DW-1:0]      fifo_wr_din;
    logic               fifo_wr_full;
    logic               fifo_wr_prog_full;
    logic               fifo_wr_error;
    logic [1:0]         grant_id;
    logic               busy;
`ifdef DTI_FIFO_WR_ARB_STAT_EN
    logic               err_sticky;
    logic [15:0]        err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    logic [DW-1:0] word_of[NReq];

    dti_fifo_wr_arb #(
        .NUM_REQ    (4),
        .DATA_WIDTH (21),
        .MAX_BURST  (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .fifo_wr_req       (fifo_wr_req),
        .fifo_wr_din       (fifo_wr_din),
        .fifo_wr_full      (fifo_wr_full),
        .fifo_wr_prog_full (fifo_wr_prog_full),
        .fifo_wr_error     (fifo_wr_error),
        .grant_id          (grant_id),
        .busy              (busy)
`ifdef DTI_FIFO_WR_ARB_STAT_EN
        ,
        .err_sticky        (err_sticky),
        .err_cnt           (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic p, input logic e, input logic [3:0] rdy, input logic wr,
                       input logic [1:0] g, input logic b);
        vec_t t;
        t.rst_n = r;   t.valid = v; t.last = l; t.full = f; t.pfull = p; t.err = e;
        t.exp_ready = rdy; t.exp_wr = wr; t.exp_gid = g; t.exp_busy = b;
        vecs.push_back(t);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = '0; req_last = '0;
        fifo_wr_full = 1'b0; fifo_wr_prog_full = 1'b0; fifo_wr_error = 1'b0;
        for (int i = 0; i < NReq; i++) begin
            word_of[i] = DW'(21'h0A5C3 + i * 21'h11111);
            req_data[i*DW +: DW] = word_of[i];
        end

        //  rst valid  last  full pf err  ready   wr gid busy
        // Reset, then all four requesting single-word packets: 0,1,2,3,0.
        add(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h1, 1, 0, 1);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'hF, 4'hF, 0, 0, 1, 4'h2, 1, 1, 1);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 1, 0);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 2, 0);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h8, 1, 3, 1);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h0, 0, 3, 0);
        add(1, 4'hF, 4'hF, 0, 0, 0, 4'h1, 1, 0, 1);
        add(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
        // Requester 2 streams 10 words; 3-cycle full stall in burst 1; req1 joins later.
        add(1, 4'h4, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'h4, 4'h0, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h4, 4'h0, 1, 0, 0, 4'h0, 0, 2, 1);
        add(1, 4'h4, 4'h0, 1, 0, 0, 4'h0, 0, 2, 1);
        add(1, 4'h4, 4'h0, 1, 0, 0, 4'h0, 0, 2, 1);
        add(1, 4'h4, 4'h0, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h4, 4'h0, 0, 0, 1, 4'h4, 1, 2, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h0, 0, 2, 0);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h2, 1, 1, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h0, 0, 1, 0);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h2, 4'h2, 0, 0, 0, 4'h4, 0, 2, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h6, 4'h2, 0, 1, 0, 4'h4, 1, 2, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h0, 0, 2, 0);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h2, 1, 1, 1);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h0, 0, 1, 0);
        add(1, 4'h6, 4'h2, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h6, 4'h6, 0, 0, 0, 4'h4, 1, 2, 1);
        add(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 2, 0);
        // prog_full holds off a grant in IDLE.
        add(1, 4'h1, 4'h1, 0, 1, 0, 4'h0, 0, 2, 0);
        add(1, 4'h1, 4'h1, 0, 1, 0, 4'h0, 0, 2, 0);
        add(1, 4'h1, 4'h1, 0, 0, 0, 4'h0, 0, 2, 0);
        add(1, 4'h1, 4'h1, 0, 0, 0, 4'h1, 1, 0, 1);
        add(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
        // Reset during word 2 of a burst; priority restarts at requester 0.
        add(1, 4'h2, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'h2, 4'h0, 0, 0, 0, 4'h2, 1, 1, 1);
        add(0, 4'h2, 4'h0, 0, 0, 0, 4'h0, 0, 1, 0);
        add(1, 4'h3, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
        add(1, 4'h3, 4'h0, 0, 0, 0, 4'h1, 1, 0, 1);
        add(1, 4'h3, 4'h1, 0, 0, 0, 4'h1, 1, 0, 1);
        add(1, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset_n           = vecs[i].rst_n;
            req_valid         = vecs[i].valid;
            req_last          = vecs[i].last;
            fifo_wr_full      = vecs[i].full;
            fifo_wr_prog_full = vecs[i].pfull;
            fifo_wr_error     = vecs[i].err;
            #2;
            check("req_ready", i, 32'(req_ready), 32'(vecs[i].exp_ready));
            check("fifo_wr_req", i, 32'(fifo_wr_req), 32'(vecs[i].exp_wr));
            check("grant_id", i, 32'(grant_id), 32'(vecs[i].exp_gid));
            check("busy", i, 32'(busy), 32'(vecs[i].exp_busy));
            check("fifo_wr_din", i, 32'(fifo_wr_din), 32'(word_of[vecs[i].exp_gid]));
        end

`ifdef DTI_FIFO_WR_ARB_STAT_EN
        // Three error pulses counted, then cleared by reset.
        @(negedge clk); reset_n = 1'b0; fifo_wr_error = 1'b0; req_valid = '0;
        @(negedge clk); reset_n = 1'b1;
        #2;
        check("err_cnt_rst", 0, 32'(err_cnt), 32'd0);
        check("err_sticky_rst", 0, 32'(err_sticky), 32'd0);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk); fifo_wr_error = 1'b1;
            @(negedge clk); fifo_wr_error = 1'b0;
        end
        #2;
        check("err_cnt", 1, 32'(err_cnt), 32'd3);
        check("err_sticky", 1, 32'(err_sticky), 32'd1);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        #2;
        check("err_cnt_clr", 2, 32'(err_cnt), 32'd0);
        check("err_sticky_clr", 2, 32'(err_sticky), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dti_fifo_wr_arb.md
DTI_FIFO_WR_ARB -- requirements
Module: dti_fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 21, data word width, equal to the async FIFO wr_din width.
REQ-003 Parameter MAX_BURST, default 4, maximum words per grant before rearbitration (1..16).
REQ-004 clk  input  1  write-clock-domain clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester word-valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  marks the final word of a requester's packet.
REQ-009 req_ready  output  NUM_REQ  word accepted when req_valid[i] & req_ready[i].
REQ-010 fifo_wr_req  output  1  drives FIFO wr_req.
REQ-011 fifo_wr_din  output  DATA_WIDTH  drives FIFO wr_din.
REQ-012 fifo_wr_full  input  1  FIFO wr_full.
REQ-013 fifo_wr_prog_full  input  1  FIFO wr_prog_full.
REQ-014 fifo_wr_error  input  1  FIFO wr_error, reports failure of the previous-cycle write.
REQ-015 grant_id  output  clog2(NUM_REQ)  index of the current or most recent grantee.
REQ-016 busy  output  1  high while in GRANT.

Function
REQ-017 FSM states: IDLE and GRANT.
REQ-018 IDLE: arbitration is round-robin over req_valid, starting at rr_ptr+1 modulo NUM_REQ.
REQ-019 IDLE: a winner is registered only when any req_valid is high and fifo_wr_prog_full is low; next state GRANT, grant_id=winner, burst_cnt=0.
REQ-020 IDLE with fifo_wr_prog_full high: no grant; state stays IDLE.
REQ-021 GRANT: req_ready[grant_id] = !fifo_wr_full; all other req_ready bits are 0.
REQ-022 req_ready is 0 for every requester in IDLE.
REQ-023 fifo_wr_req = req_valid[grant_id] & req_ready[grant_id], combinational, zero-cycle latency.
REQ-024 fifo_wr_din = req_data slice of grant_id, combinational.
REQ-025 Each accepted word increments burst_cnt (width clog2(MAX_BURST)+1).
REQ-026 GRANT->IDLE on an accepted word that has req_last high or that makes burst_cnt reach MAX_BURST; rr_ptr is updated to grant_id on that transition.
REQ-027 A burst is not preempted by fifo_wr_prog_full; only fifo_wr_full stalls it, by holding ready low.
REQ-028 A requester deasserting valid mid-burst keeps the grant; there is no timeout.
REQ-029 Minimum of one IDLE cycle between grants.
REQ-030 Single requester with MAX_BURST=1: one word every 2 cycles.
REQ-031 fifo_wr_error never alters FSM state or ordering; no replay is performed.

Reset
REQ-032 While reset_n is low at a clk edge: state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority), burst_cnt=0.
REQ-033 While reset_n is low, req_ready=0, fifo_wr_req=0, busy=0.
REQ-034 Reset asserted mid-burst aborts the burst immediately; no word is written during the reset cycle.

Configuration
REQ-035 Macro DTI_FIFO_WR_ARB_STAT_EN defined adds output err_sticky (1): set on any fifo_wr_error, cleared only by reset.
REQ-036 Macro DTI_FIFO_WR_ARB_STAT_EN defined adds output err_cnt (16): incremented per fifo_wr_error, saturating at 16'hFFFF, reset to 0.
REQ-037 Macro DTI_FIFO_WR_ARB_STAT_EN undefined: these ports and their registers are absent, and fifo_wr_error is unused.

Structure
REQ-038 Package dti_fifo_wr_arb_pkg holds the FSM state typedef (IDLE, GRANT) and the MAX_BURST/NUM_REQ range-check constants.
REQ-039 Sub-module dti_rr_arbiter: combinational round-robin picker taking req vector and rr_ptr, returning winner index and valid.

Verification
REQ-040 After reset, req_valid=4'b1111 with req_last=1 each word -> grants in order 0,1,2,3,0; one word per grant; one IDLE cycle between grants.
REQ-041 Requester 2 streams a 10-word packet, MAX_BURST=4 -> bursts of 4,4,2 words; requester 1, also valid, is granted between bursts.
REQ-042 fifo_wr_full high for 3 cycles mid-burst -> req_ready=0 and fifo_wr_req=0 for those 3 cycles; no word lost or duplicated.
REQ-043 fifo_wr_prog_full high in IDLE with req_valid=4'b0001 -> no grant until prog_full falls; next cycle grant_id=0.
REQ-044 reset_n low for 1 cycle during word 2 of a burst -> state IDLE, next grant to requester 0, ready low during reset.
REQ-045 With DTI_FIFO_WR_ARB_STAT_EN, 3 fifo_wr_error pulses -> err_cnt=3, err_sticky=1; both cleared by reset.
